// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store sequencer between the core and a
// word-wide data memory. Sub-word stores use read-modify-write; misaligned and
// reserved-size requests complete with ERR and never touch memory.
module load_store_unit #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REQ,
   input  logic                     WR,
   input  logic [1:0]               SIZE,
   input  logic                     UNSIGNED,
   input  logic [ADDRESS_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0]    WDATA,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     ERR,
   output logic [DATA_WIDTH-1:0]    RDATA,
   output logic [ADDRESS_WIDTH-1:0] MEM_A,
   output logic                     MEM_WE,
   output logic [DATA_WIDTH-1:0]    MEM_WD,
   input  logic [DATA_WIDTH-1:0]    MEM_RD
);

   localparam int unsigned BYTE_EXT = DATA_WIDTH - 8;
   localparam int unsigned HALF_EXT = DATA_WIDTH - 16;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_RMW_READ = 3'd2,
      S_WRITE    = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    accept_c;
   logic                    req_err_c;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [1:0]              off_q;
   logic [15:0]             sub_wdata_q;
   logic [7:0]              lane_b_c;
   logic [15:0]             lane_h_c;
   logic [DATA_WIDTH-1:0]   load_c;
   logic [DATA_WIDTH-1:0]   merge_c;

   assign accept_c = (state_q == S_IDLE) && REQ;

   // Reject reserved sizes and addresses not aligned to the access size
   always_comb begin
      req_err_c = 1'b0;
      case (SIZE)
         SZ_HALF: req_err_c = ADDR[0];
         SZ_WORD: req_err_c = |ADDR[1:0];
         SZ_RSVD: req_err_c = 1'b1;
         default: req_err_c = 1'b0;
      endcase
   end

   // State register; reset returns to IDLE at once, which drops MEM_WE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               if (req_err_c) begin
                  state_d = S_RESP;
               end else if (!WR) begin
                  state_d = S_LOAD;
               end else if (SIZE == SZ_WORD) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_RMW_READ;
               end
            end
         end
         S_LOAD:     state_d = S_RESP;
         S_RMW_READ: state_d = S_WRITE;
         S_WRITE:    state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // State-decoded stall and write strobe
   always_comb begin
      BUSY   = 1'b0;
      MEM_WE = 1'b0;
      case (state_q)
         S_LOAD, S_RMW_READ: BUSY = 1'b1;
         S_WRITE: begin
            BUSY   = 1'b1;
            MEM_WE = 1'b1;
         end
         default: begin
            BUSY   = 1'b0;
            MEM_WE = 1'b0;
         end
      endcase
   end

   // Select the addressed lane of the memory word and extend it
   always_comb begin
      lane_b_c = MEM_RD[7:0];
      case (off_q)
         2'd1:    lane_b_c = MEM_RD[15:8];
         2'd2:    lane_b_c = MEM_RD[23:16];
         2'd3:    lane_b_c = MEM_RD[31:24];
         default: lane_b_c = MEM_RD[7:0];
      endcase
      lane_h_c = off_q[1] ? MEM_RD[31:16] : MEM_RD[15:0];
      load_c   = MEM_RD;
      case (size_q)
         SZ_BYTE: load_c = {{BYTE_EXT{~uns_q & lane_b_c[7]}}, lane_b_c};
         SZ_HALF: load_c = {{HALF_EXT{~uns_q & lane_h_c[15]}}, lane_h_c};
         default: load_c = MEM_RD;
      endcase
   end

   // Overlay the store data onto the addressed lane of the current word
   always_comb begin
      merge_c = MEM_RD;
      if (size_q == SZ_BYTE) begin
         case (off_q)
            2'd1:    merge_c[15:8]  = sub_wdata_q[7:0];
            2'd2:    merge_c[23:16] = sub_wdata_q[7:0];
            2'd3:    merge_c[31:24] = sub_wdata_q[7:0];
            default: merge_c[7:0]   = sub_wdata_q[7:0];
         endcase
      end else if (off_q[1]) begin
         merge_c[31:16] = sub_wdata_q;
      end else begin
         merge_c[15:0] = sub_wdata_q;
      end
   end

   // Request capture, word address and merge/write-data register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         off_q       <= 2'b00;
         sub_wdata_q <= 16'h0000;
         MEM_A       <= '0;
         MEM_WD      <= '0;
      end else begin
         if (accept_c) begin
            size_q      <= SIZE;
            uns_q       <= UNSIGNED;
            off_q       <= ADDR[1:0];
            sub_wdata_q <= WDATA[15:0];
            MEM_A       <= {2'b00, ADDR[ADDRESS_WIDTH-1:2]};
            if (WR && (SIZE == SZ_WORD) && !req_err_c) begin
               MEM_WD <= WDATA;
            end
         end
         if (state_q == S_RMW_READ) begin
            MEM_WD <= merge_c;
         end
      end
   end

   // Load result register; only a completed load updates it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RDATA <= '0;
      end else if (state_q == S_LOAD) begin
         RDATA <= load_c;
      end
   end

   // Completion pulse; only a rejected request goes straight from IDLE to RESP
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
      end else begin
         DONE <= (state_d == S_RESP);
         ERR  <= accept_c && req_err_c;
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store sequencer between the core datapath (ALU result, rt register, control unit) and the word-wide data memory. It accepts one access request at a time and supports byte, halfword and word loads (signed or zero-extended) and stores. Sub-word stores are implemented as read-modify-write, because the data memory only writes whole words. Misaligned and reserved-size requests are rejected without touching memory. The core stalls on BUSY.

## Interface
- ADDRESS_WIDTH, 32, byte-address width of ADDR and word-address width of MEM_A
- DATA_WIDTH, 32, data word width; only 32 is supported
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  access request; sampled only in IDLE
- WR  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
- UNSIGNED  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- ADDR  in  ADDRESS_WIDTH  byte address
- WDATA  in  DATA_WIDTH  store data; sub-word data in the low bits
- BUSY  out  1  access in progress; core must stall
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  high together with DONE when the request was rejected
- RDATA  out  DATA_WIDTH  load result; held until the next load completes
- MEM_A  out  ADDRESS_WIDTH  word address to data memory
- MEM_WE  out  1  data memory write enable
- MEM_WD  out  DATA_WIDTH  data memory write data
- MEM_RD  in  DATA_WIDTH  data memory read data, combinational from MEM_A

## Operation
- **States:** IDLE, LOAD, RMW_READ, WRITE, RESP. Reset state is IDLE.
- **Accept (IDLE with REQ=1):** latch WR, SIZE, UNSIGNED, ADDR[1:0] and WDATA; set MEM_A register to {2'b00, ADDR[31:2]}.
- **Error check at accept:**
  - SIZE=11 is an error.
  - SIZE=01 with ADDR[0]=1 is an error.
  - SIZE=10 with ADDR[1:0]≠00 is an error.
  - On error: go to RESP with the error flag set.
- **Next state after a valid accept:**
  - Load goes to LOAD.
  - Word store goes to WRITE, with the merge register set to WDATA.
  - Byte or halfword store goes to RMW_READ.
- **LOAD:** extract from MEM_RD, extend, register into RDATA, then go to RESP.
  - Byte lane k = ADDR[1:0] is bits [8k+7:8k].
  - Halfword lane is bits [16·ADDR[1]+15 : 16·ADDR[1]].
- **RMW_READ:** merge register = MEM_RD with the addressed byte or halfword lane replaced by WDATA[7:0] or WDATA[15:0]; then go to WRITE.
- **WRITE:** MEM_WE=1 and MEM_WD = merge register for exactly this cycle; then go to RESP.
- **RESP:** DONE=1; ERR = error flag. Always return to IDLE. REQ is ignored in RESP.
- **Combinational outputs:**
  - BUSY = 1 in LOAD, RMW_READ and WRITE; 0 in IDLE and RESP.
  - MEM_WE = 1 only in WRITE.
- **Unaffected registers:** RDATA changes only on a successful load. Errors and stores leave RDATA unchanged.
- **Reset values:** state IDLE; BUSY, DONE, ERR, MEM_WE = 0; RDATA, MEM_A, MEM_WD = 0.
- **Reset mid-operation:** asserting RST in any state returns to IDLE immediately and drops MEM_WE asynchronously. No partial write may occur after RST rises.

## Timing
- Request accepted at edge E0. DONE is high during the cycle following:
  - load: E2 (2-cycle latency);
  - word store: E2;
  - sub-word store: E3;
  - error: E1.
- MEM_WE is high for exactly one cycle per store:
  - word store: between E1 and E2;
  - sub-word store: between E2 and E3.
- RDATA is valid from E2 for loads, the same cycle DONE rises.
- Back-to-back requests: the earliest next accept is the IDLE cycle after RESP. Throughput is 1 access per 3 cycles (load/word store) or 4 cycles (sub-word store).
- MEM_RD is sampled at the end of LOAD and RMW_READ only. MEM_A is stable from E0 until the next accept.

## Test plan
- **Word round trip:** after reset, SW ADDR=0x0 WDATA=0x11223344, then LW ADDR=0x0 -> MEM_WE one pulse with MEM_A=0, MEM_WD=0x11223344; RDATA=0x11223344 with DONE at E2; ERR=0.
- **Sub-word store:** word 0 = 0x11223344; SB ADDR=0x1 WDATA=0xFFFFFFAB -> MEM_WD=0x1122AB44; SH ADDR=0x2 WDATA=0x8001 -> MEM_WD=0x8001AB44; DONE at E3 each.
- **Sub-word loads:** word 0 = 0x8001AB44 ->
  - LH ADDR=0x2 signed: RDATA=0xFFFF8001;
  - LHU ADDR=0x2: RDATA=0x00008001;
  - LB ADDR=0x1: RDATA=0xFFFFFFAB;
  - LBU ADDR=0x0: RDATA=0x00000044.
- **Misalignment/reserved:** LW ADDR=0x6, SH ADDR=0x3, and SIZE=11 -> DONE and ERR at E1; MEM_WE never asserted; RDATA keeps its previous value.
- **Reset mid-store:** assert RST during the WRITE cycle of an SB -> MEM_WE falls without waiting for a clock edge; all outputs return to 0; a subsequent LW of that word returns its unmodified value.
- **Request during busy/RESP:** hold REQ high continuously across 3 loads to ADDR 0x0, 0x4, 0x8 -> accepts occur only in IDLE; DONE pulses are spaced 3 cycles apart with correct RDATA for each.
